id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage MIPS pipeline. It consumes the 65-bit IF/ID word produced by instruction fetch, decodes the instruction and reads the 32×32 register file. It detects load-use hazards and stalls fetch, and registers a decoded ID/EX bundle for execute. It also owns the pipeline halt: the all-ones instruction stops decode permanently until reset.

## Interface
Parameters:
- NREG, 32, register-file depth; register 0 is hardwired zero.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- ifid  in  65  [64] halt flag, [63:32] pc+4, [31:0] instruction.
- ifid_valid  in  1  ifid holds a real instruction.
- flush  in  1  discard the current ifid (taken branch/jump resolved downstream).
- ex_memread  in  1  instruction now in EX is a load.
- ex_rt  in  5  destination of that load.
- wb_we, wb_addr, wb_data  in  1/5/32  register-file write port.
- stall  out  1  combinational; IF must hold pc and ifid this cycle.
- halted  out  1  registered; decode has retired the halt word.
- idex_valid, idex_halt  out  1/1  bundle valid; bundle is the halt marker.
- idex_pc4, idex_rs_val, idex_rt_val, idex_imm  out  32 each.
- idex_jtarget  out  32  {pc4[31:28], inst[25:0], 2'b00}.
- idex_rs, idex_rt, idex_dst, idex_shamt  out  5 each.
- idex_aluop  out  4  ALU operation code (package enum).
- idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc  out  1 each.
- idex_br  out  2  0 none, 1 beq, 2 bne, 3 jump.

## Operation
- States: RUN, HALTED. Reset → RUN.
- RUN, per cycle, in priority order:
  - flush: load a bubble.
  - !ifid_valid: load a bubble.
  - stall: load a bubble.
  - ifid[64]: emit the halt marker (idex_valid=1, idex_halt=1, all control bits 0), then go to HALTED.
  - Otherwise: load the decoded bundle with idex_valid=1.
- Bubble: idex_valid=0; all control bits, aluop and br are 0. Data fields are don't-care but driven 0.
- HALTED: stall=0, every cycle a bubble, halted=1. Leave only by reset.
- stall = RUN & ifid_valid & !flush & ex_memread & ex_rt≠0 & (ex_rt==rs | (uses_rt & ex_rt==rt)).
  - uses_rt is 1 for R-type, sw, beq and bne.
- Decoded set:
  - R-type add, addu, sub, subu, and, or, xor, nor, slt, sll, srl, sra, jr.
  - I-type addi, addiu, andi, ori, xori, slti, lui, lw, sw, beq, bne.
  - J-type j, jal.
- Immediate:
  - sign-extend for addi, addiu, slti, lw, sw, beq, bne.
  - zero-extend for andi, ori, xori.
  - lui → {inst[15:0], 16'h0}.
- Destination:
  - rd for R-type.
  - rt for I-type writes.
  - 31 for jal; jal sets regwrite=1 and aluop=PASS_PC4.
- Illegal opcode or funct: decoded as a bubble (idex_valid=0). It does not stall and does not halt.
- Register file: written on rising CLK when wb_we & wb_addr≠0.
  - Reads are combinational with write-through bypass: same-cycle wb_addr==rs/rt returns wb_data.
  - Register 0 always reads 0.

## Timing
- Decode latency is 1 cycle: ifid sampled at edge N appears on idex_* after edge N.
- stall is combinational from ifid, ex_memread and ex_rt within the same cycle. During a stalled cycle IF holds, so the instruction is re-decoded next cycle.
- A load-use pair inserts exactly one bubble.
- Reset (asynchronous, any time, including mid-stall or in HALTED):
  - all idex_* outputs = 0, halted=0, stall=0.
  - all registers = 0, state = RUN.
- Reset release: first decode on the first rising edge with RESET=1.
- Simultaneous flush and halt word: flush wins. Halt is not retired and the state stays RUN.
- Write-back and read of the same register in one cycle: the new value is decoded (bypass).

## Structure
- Shared package (shared with EX):
  - opcode and funct constants.
  - the aluop enum: ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA, LUI, PASS_PC4.
  - br encodings.
  - halt word 32'hFFFF_FFFF.
  - IF/ID field offsets.
- Sub-module regfile: 32×32 storage, asynchronous clear, two read ports with bypass, one write port.
- id_stage holds the decoder, hazard unit, state register and ID/EX registers.

## Test plan
- addi $1,$0,-5 (0x2001FFFB), pc4=0x4 → next cycle:
  - idex_valid=1, imm=0xFFFFFFFB, dst=1, regwrite=1, alusrc=1, aluop=ADD.
- wb writes $3=0x1234 while ifid decodes or $4,$3,$0 → idex_rs_val=0x1234 (bypass).
  - wb to $0 → $0 still reads 0.
- Load-use: ex_memread=1, ex_rt=2, ifid=add $5,$2,$1 →
  - stall=1 and a bubble for one cycle.
  - Next cycle with ex_memread=0 → valid add bundle.
- ifid=0xFFFFFFFF valid →
  - halt marker with valid=1 and halt=1.
  - then halted=1 and only bubbles; a following valid addi produces nothing.
  - RESET low → all outputs 0; after release decoding resumes.
- flush=1 with a valid sw and ex load hazard → bubble, stall=0.
- jal with inst[25:0]=0x0000100 and pc4=0x0040_0008 → jtarget=0x0000_0400, dst=31, br=3, aluop=PASS_PC4.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared ID/EX definitions: opcodes, functs, ALU/branch encodings, IF/ID layout,
// ID/EX bundle and the instruction decoder helper.
package id_stage_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned RAW           = 5;
    localparam int unsigned IFID_W        = 65;
    localparam int unsigned IFID_HALT     = 64;
    localparam int unsigned IFID_PC4_LSB  = 32;
    localparam int unsigned IFID_INST_LSB = 0;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASS_PC4
    } aluop_e;

    typedef enum logic [1:0] {BR_NONE, BR_BEQ, BR_BNE, BR_JUMP} br_e;
    typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_e;
    typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_RA} dst_e;
    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    typedef struct packed {
        logic   legal;
        logic   uses_rt;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   alusrc;
        aluop_e aluop;
        br_e    br;
        imm_e   imm;
        dst_e   dst;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic        halt;
        logic [31:0] pc4;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] jtarget;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [4:0]  shamt;
        aluop_e      aluop;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        br_e         br;
    } idex_t;

    // Control decode; unknown opcode/funct returns legal=0 with all controls clear.
    function automatic ctrl_t decode(input logic [31:0] inst);
        ctrl_t      c;
        logic [5:0] op;
        logic [5:0] fn;
        c  = '0;
        op = inst[31:26];
        fn = inst[5:0];
        case (op)
            OP_RTYPE: begin
                c.legal    = 1'b1;
                c.uses_rt  = 1'b1;
                c.regwrite = 1'b1;
                c.dst      = DST_RD;
                case (fn)
                    FN_ADD, FN_ADDU: c.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: c.aluop = ALU_SUB;
                    FN_AND:          c.aluop = ALU_AND;
                    FN_OR:           c.aluop = ALU_OR;
                    FN_XOR:          c.aluop = ALU_XOR;
                    FN_NOR:          c.aluop = ALU_NOR;
                    FN_SLT:          c.aluop = ALU_SLT;
                    FN_SLL:          c.aluop = ALU_SLL;
                    FN_SRL:          c.aluop = ALU_SRL;
                    FN_SRA:          c.aluop = ALU_SRA;
                    FN_JR: begin
                        // Register jump: EX redirects to rs_val.
                        c.regwrite = 1'b0;
                        c.dst      = DST_NONE;
                        c.br       = BR_JUMP;
                    end
                    default:         c = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                c.legal = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst = DST_RT;
            end
            OP_SLTI: begin
                c.legal = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst = DST_RT;
                c.aluop = ALU_SLT;
            end
            OP_ANDI: begin
                c.legal = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst = DST_RT;
                c.aluop = ALU_AND; c.imm = IMM_ZEXT;
            end
            OP_ORI: begin
                c.legal = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst = DST_RT;
                c.aluop = ALU_OR; c.imm = IMM_ZEXT;
            end
            OP_XORI: begin
                c.legal = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst = DST_RT;
                c.aluop = ALU_XOR; c.imm = IMM_ZEXT;
            end
            OP_LUI: begin
                c.legal = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst = DST_RT;
                c.aluop = ALU_LUI; c.imm = IMM_LUI;
            end
            OP_LW: begin
                c.legal = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; c.dst = DST_RT;
                c.memread = 1'b1; c.memtoreg = 1'b1;
            end
            OP_SW: begin
                c.legal = 1'b1; c.uses_rt = 1'b1; c.alusrc = 1'b1; c.memwrite = 1'b1;
            end
            OP_BEQ: begin
                c.legal = 1'b1; c.uses_rt = 1'b1; c.aluop = ALU_SUB; c.br = BR_BEQ;
            end
            OP_BNE: begin
                c.legal = 1'b1; c.uses_rt = 1'b1; c.aluop = ALU_SUB; c.br = BR_BNE;
            end
            OP_J: begin
                c.legal = 1'b1; c.br = BR_JUMP;
            end
            OP_JAL: begin
                c.legal = 1'b1; c.br = BR_JUMP; c.regwrite = 1'b1; c.dst = DST_RA;
                c.aluop = ALU_PASS_PC4;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: async clear, one write port, two combinational read
// ports with write-through bypass; register 0 reads as zero.
//   clk_i, rst_ni          clock, async active-low clear
//   we_i, waddr_i, wdata_i write port
//   raddr_a_i/rdata_a_o    read port A (rs)
//   raddr_b_i/rdata_b_o    read port B (rt)
module id_stage_regfile
    import id_stage_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [RAW-1:0]  waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [RAW-1:0]  raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [RAW-1:0]  raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] mem_q [NREG];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle write-back is forwarded so decode sees the new value.
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i != '0) begin
            rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
        end
        if (raddr_b_i != '0) begin
            rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decodes IF/ID, reads the register file,
// detects load-use hazards (combinational stall), registers the ID/EX bundle
// and owns the sticky pipeline halt.
//   CLK, RESET                    clock, async active-low reset
//   ifid, ifid_valid, flush       IF/ID word {halt, pc+4, inst} and control
//   ex_memread, ex_rt             load currently in EX, for hazard detection
//   wb_we, wb_addr, wb_data       register-file write port
//   stall                         combinational: IF holds this cycle
//   halted                        halt word has been retired
//   idex_*                        registered ID/EX bundle
module id_stage
    import id_stage_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [IFID_W-1:0] ifid,
    input  logic              ifid_valid,
    input  logic              flush,
    input  logic              ex_memread,
    input  logic [RAW-1:0]    ex_rt,
    input  logic              wb_we,
    input  logic [RAW-1:0]    wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall,
    output logic              halted,
    output logic              idex_valid,
    output logic              idex_halt,
    output logic [XLEN-1:0]   idex_pc4,
    output logic [XLEN-1:0]   idex_rs_val,
    output logic [XLEN-1:0]   idex_rt_val,
    output logic [XLEN-1:0]   idex_imm,
    output logic [XLEN-1:0]   idex_jtarget,
    output logic [RAW-1:0]    idex_rs,
    output logic [RAW-1:0]    idex_rt,
    output logic [RAW-1:0]    idex_dst,
    output logic [RAW-1:0]    idex_shamt,
    output aluop_e            idex_aluop,
    output logic              idex_regwrite,
    output logic              idex_memread,
    output logic              idex_memwrite,
    output logic              idex_memtoreg,
    output logic              idex_alusrc,
    output logic [1:0]        idex_br
);

    state_e          state_q, state_d;
    idex_t           idex_q, idex_d;
    logic [XLEN-1:0] inst, pc4, rs_val, rt_val, imm;
    logic [RAW-1:0]  rs, rt, rd, dst;
    ctrl_t           ctrl;
    logic            halt_req;

    assign inst     = ifid[IFID_INST_LSB +: XLEN];
    assign pc4      = ifid[IFID_PC4_LSB +: XLEN];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign ctrl     = decode(inst);
    assign halt_req = ifid[IFID_HALT] || (inst == HALT_WORD);

    id_stage_regfile #(.NREG(NREG)) u_regfile (
        .clk_i     (CLK),
        .rst_ni    (RESET),
        .we_i      (wb_we),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs),
        .rdata_a_o (rs_val),
        .raddr_b_i (rt),
        .rdata_b_o (rt_val)
    );

    // Immediate and destination selection.
    always_comb begin
        imm = {{16{inst[15]}}, inst[15:0]};
        case (ctrl.imm)
            IMM_ZEXT: imm = {16'h0, inst[15:0]};
            IMM_LUI:  imm = {inst[15:0], 16'h0};
            default:  imm = {{16{inst[15]}}, inst[15:0]};
        endcase
        case (ctrl.dst)
            DST_RD:  dst = rd;
            DST_RT:  dst = rt;
            DST_RA:  dst = 5'd31;
            default: dst = '0;
        endcase
    end

    // Next state, hazard detection and next ID/EX bundle.
    always_comb begin
        state_d = state_q;
        idex_d  = '0;
        stall   = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall = ifid_valid && !flush && ex_memread && (ex_rt != '0) &&
                        ((ex_rt == rs) || (ctrl.uses_rt && (ex_rt == rt)));
                if (flush || !ifid_valid || stall) begin
                    idex_d = '0;
                end else if (halt_req) begin
                    idex_d.valid = 1'b1;
                    idex_d.halt  = 1'b1;
                    state_d      = ST_HALTED;
                end else if (ctrl.legal) begin
                    idex_d.valid    = 1'b1;
                    idex_d.pc4      = pc4;
                    idex_d.rs_val   = rs_val;
                    idex_d.rt_val   = rt_val;
                    idex_d.imm      = imm;
                    idex_d.jtarget  = {pc4[31:28], inst[25:0], 2'b00};
                    idex_d.rs       = rs;
                    idex_d.rt       = rt;
                    idex_d.dst      = dst;
                    idex_d.shamt    = inst[10:6];
                    idex_d.aluop    = ctrl.aluop;
                    idex_d.regwrite = ctrl.regwrite;
                    idex_d.memread  = ctrl.memread;
                    idex_d.memwrite = ctrl.memwrite;
                    idex_d.memtoreg = ctrl.memtoreg;
                    idex_d.alusrc   = ctrl.alusrc;
                    idex_d.br       = ctrl.br;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_RUN;
            idex_q  <= '0;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

    assign halted        = (state_q == ST_HALTED);
    assign idex_valid    = idex_q.valid;
    assign idex_halt     = idex_q.halt;
    assign idex_pc4      = idex_q.pc4;
    assign idex_rs_val   = idex_q.rs_val;
    assign idex_rt_val   = idex_q.rt_val;
    assign idex_imm      = idex_q.imm;
    assign idex_jtarget  = idex_q.jtarget;
    assign idex_rs       = idex_q.rs;
    assign idex_rt       = idex_q.rt;
    assign idex_dst      = idex_q.dst;
    assign idex_shamt    = idex_q.shamt;
    assign idex_aluop    = idex_q.aluop;
    assign idex_regwrite = idex_q.regwrite;
    assign idex_memread  = idex_q.memread;
    assign idex_memwrite = idex_q.memwrite;
    assign idex_memtoreg = idex_q.memtoreg;
    assign idex_alusrc   = idex_q.alusrc;
    assign idex_br       = idex_q.br;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with hand-computed expected values.
module tb_id_stage;

    logic        CLK;
    logic        RESET;
    logic [64:0] ifid;
    logic        ifid_valid, flush, ex_memread, wb_we;
    logic [4:0]  ex_rt, wb_addr;
    logic [31:0] wb_data;
    logic        stall, halted, idex_valid, idex_halt;
    logic [31:0] idex_pc4, idex_rs_val, idex_rt_val, idex_imm, idex_jtarget;
    logic [4:0]  idex_rs, idex_rt, idex_dst, idex_shamt;
    logic [3:0]  idex_aluop;
    logic        idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc;
    logic [1:0]  idex_br;

    int n_pass  = 0;
    int n_total = 0;

    id_stage #(.NREG(32)) dut (
        .CLK(CLK), .RESET(RESET), .ifid(ifid), .ifid_valid(ifid_valid), .flush(flush),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .stall(stall), .halted(halted), .idex_valid(idex_valid),
        .idex_halt(idex_halt), .idex_pc4(idex_pc4), .idex_rs_val(idex_rs_val),
        .idex_rt_val(idex_rt_val), .idex_imm(idex_imm), .idex_jtarget(idex_jtarget),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_dst(idex_dst), .idex_shamt(idex_shamt),
        .idex_aluop(idex_aluop), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg),
        .idex_alusrc(idex_alusrc), .idex_br(idex_br)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic hf, input logic [31:0] pc, input logic [31:0] ins);
        ifid       = {hf, pc, ins};
        ifid_valid = 1'b1;
    endtask

    initial begin
        RESET = 1'b0; ifid = '0; ifid_valid = 1'b0; flush = 1'b0;
        ex_memread = 1'b0; ex_rt = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        #3;
        chk("rst_valid",  32'(idex_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_stall",  32'(stall), 0);
        chk("rst_pc4",    idex_pc4, 0);
        #9 RESET = 1'b1;

        // addi $1,$0,-5
        drive(1'b0, 32'h4, 32'h2001FFFB);
        step();
        chk("addi_valid", 32'(idex_valid), 1);
        chk("addi_imm",   idex_imm, 32'hFFFFFFFB);
        chk("addi_dst",   32'(idex_dst), 1);
        chk("addi_rw",    32'(idex_regwrite), 1);
        chk("addi_src",   32'(idex_alusrc), 1);
        chk("addi_alu",   32'(idex_aluop), 0);
        chk("addi_pc4",   idex_pc4, 32'h4);

        // or $4,$3,$0 while wb writes $3 -> bypass
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
        drive(1'b0, 32'h8, 32'h00602025);
        step();
        chk("byp_rsval", idex_rs_val, 32'h1234);
        chk("or_dst",    32'(idex_dst), 4);
        chk("or_alu",    32'(idex_aluop), 3);

        // wb to $0 ignored; or $4,$0,$3 reads $3 from storage
        wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
        drive(1'b0, 32'hC, 32'h00032025);
        step();
        chk("r0_rsval",  idex_rs_val, 0);
        chk("r3_rtval",  idex_rt_val, 32'h1234);
        wb_we = 1'b0;

        // load-use on rs: add $5,$2,$1 with lw $2 in EX
        ex_memread = 1'b1; ex_rt = 5'd2;
        drive(1'b0, 32'h10, 32'h00412820);
        #1;
        chk("lu_stall", 32'(stall), 1);
        step();
        chk("lu_bubble_v",  32'(idex_valid), 0);
        chk("lu_bubble_rw", 32'(idex_regwrite), 0);
        ex_memread = 1'b0;
        #1;
        chk("lu_nostall", 32'(stall), 0);
        step();
        chk("add_valid", 32'(idex_valid), 1);
        chk("add_dst",   32'(idex_dst), 5);
        chk("add_rs",    32'(idex_rs), 2);
        chk("add_rt",    32'(idex_rt), 1);

        // sw $2,0($1): hazard through rt, then flushed
        ex_memread = 1'b1; ex_rt = 5'd2;
        drive(1'b0, 32'h14, 32'hAC220000);
        #1;
        chk("sw_rt_stall", 32'(stall), 1);
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 0);
        step();
        chk("flush_valid", 32'(idex_valid), 0);
        chk("flush_mw",    32'(idex_memwrite), 0);
        flush = 1'b0; ex_memread = 1'b0; ex_rt = '0;

        // jal
        drive(1'b0, 32'h00400008, 32'h0C000100);
        step();
        chk("jal_jt",  idex_jtarget, 32'h00000400);
        chk("jal_dst", 32'(idex_dst), 31);
        chk("jal_br",  32'(idex_br), 3);
        chk("jal_alu", 32'(idex_aluop), 11);
        chk("jal_rw",  32'(idex_regwrite), 1);

        // beq $1,$2,-1
        drive(1'b0, 32'h20, 32'h1022FFFF);
        step();
        chk("beq_br",  32'(idex_br), 1);
        chk("beq_alu", 32'(idex_aluop), 1);
        chk("beq_imm", idex_imm, 32'hFFFFFFFF);
        chk("beq_rw",  32'(idex_regwrite), 0);

        // lui / andi immediates
        drive(1'b0, 32'h24, 32'h3C011234);
        step();
        chk("lui_imm", idex_imm, 32'h12340000);
        chk("lui_alu", 32'(idex_aluop), 10);
        drive(1'b0, 32'h28, 32'h3021FFFF);
        step();
        chk("andi_imm", idex_imm, 32'h0000FFFF);

        // lw $7,4($1)
        drive(1'b0, 32'h2C, 32'h8C270004);
        step();
        chk("lw_mr",  32'(idex_memread), 1);
        chk("lw_m2r", 32'(idex_memtoreg), 1);
        chk("lw_dst", 32'(idex_dst), 7);

        // illegal opcode -> bubble, no stall, no halt
        drive(1'b0, 32'h30, 32'hF8000000);
        #1;
        chk("ill_stall", 32'(stall), 0);
        step();
        chk("ill_valid",  32'(idex_valid), 0);
        chk("ill_halted", 32'(halted), 0);

        // flush beats halt
        flush = 1'b1;
        drive(1'b1, 32'h34, 32'hFFFFFFFF);
        step();
        chk("fh_valid",  32'(idex_valid), 0);
        chk("fh_halted", 32'(halted), 0);
        flush = 1'b0;
        step();
        chk("halt_valid",  32'(idex_valid), 1);
        chk("halt_marker", 32'(idex_halt), 1);
        chk("halt_rw",     32'(idex_regwrite), 0);
        chk("halted_set",  32'(halted), 1);

        // in HALTED: bubbles only, no stall
        drive(1'b0, 32'h38, 32'h2001FFFB);
        step();
        chk("h_valid",  32'(idex_valid), 0);
        chk("h_halt",   32'(idex_halt), 0);
        chk("h_halted", 32'(halted), 1);
        ex_memread = 1'b1; ex_rt = 5'd2;
        drive(1'b0, 32'h3C, 32'h00412820);
        #1;
        chk("h_stall", 32'(stall), 0);
        ex_memread = 1'b0; ex_rt = '0;

        // async reset in HALTED, then resume
        RESET = 1'b0;
        #1;
        chk("r2_halted", 32'(halted), 0);
        chk("r2_valid",  32'(idex_valid), 0);
        chk("r2_stall",  32'(stall), 0);
        chk("r2_halt",   32'(idex_halt), 0);
        #1 RESET = 1'b1;
        drive(1'b0, 32'h4, 32'h2001FFFB);
        step();
        chk("res_valid", 32'(idex_valid), 1);
        chk("res_imm",   idex_imm, 32'hFFFFFFFB);
        chk("res_r3",    32'(halted), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
